// File: rtl/sdischg_pkg.sv
// Shared types and constants for the soft-discharge pulse generator.
package sdischg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BASIC  = 2'd1,
        ST_PWM_HI = 2'd2,
        ST_PWM_LO = 2'd3
    } state_t;

    localparam int unsigned SLOTS  = 32;
    localparam int unsigned SLOT_W = $clog2(SLOTS);

    // SFR bit positions feeding this block
    localparam int unsigned SRCCTL_DISCHG    = 4;
    localparam int unsigned SD_VIN           = 5;
    localparam int unsigned SD_VBUS          = 6;
    localparam int unsigned LDBPRO_OTPI_GATE = 6;

    // True while the PWM engine owns the outputs
    function automatic logic is_pwm(input state_t s);
        return (s == ST_PWM_HI) || (s == ST_PWM_LO);
    endfunction

endpackage

// File: rtl/sdischg_slot_cnt.sv
// Slot timebase: prescaler of SLOT_DIV clocks advancing a 32-slot counter.
module sdischg_slot_cnt
    import sdischg_pkg::*;
#(
    parameter int unsigned SLOT_DIV = 120
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_slot_wrap_c,
    output logic              o_period_wrap_c
);

    localparam int unsigned      PRE_W   = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SLOT_DIV - 1);

    logic [PRE_W-1:0]  r_presc;
    logic [SLOT_W-1:0] r_slot;

    assign o_slot          = r_slot;
    assign o_slot_wrap_c   = (r_presc == PRE_MAX);
    assign o_period_wrap_c = o_slot_wrap_c && (r_slot == SLOT_W'(SLOTS - 1));

    // Prescaler and slot counter; slot 31 rolls naturally to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_slot  <= '0;
        end else if (i_clear) begin
            r_presc <= '0;
            r_slot  <= '0;
        end else if (o_slot_wrap_c) begin
            r_presc <= '0;
            r_slot  <= r_slot + SLOT_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/sdischg_pwm.sv
// Soft-discharge enable generator: plain level or 32-slot PWM, with OTP gating.
module sdischg_pwm
    import sdischg_pkg::*;
#(
    parameter int unsigned SLOT_DIV = 120,
    parameter int unsigned SYNC_STG = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dischg_en,
    input  logic [4:0] sd_duty,
    input  logic       sd_vin,
    input  logic       sd_vbus,
    input  logic       otpi_gate,
    input  logic       otpi,
    output logic       vo_dischg,
    output logic       vo_vin_dischg,
    output logic       pwm_busy
);

    state_t              r_state;
    logic [SLOT_W-1:0]   r_duty;
    logic [SYNC_STG-1:0] r_otpi_sync;
    logic                r_vo_dischg;
    logic                r_vo_vin_dischg;
    logic                r_pwm_busy;

    logic [SLOT_W-1:0]   w_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [SLOT_W-1:0]   w_duty_nxt;
    logic                w_slot_wrap;
    logic                w_period_wrap;
    logic                w_sd_any;
    logic                w_gate;
    logic                w_clear;
    logic                w_hi_nxt;

    assign w_sd_any   = sd_vbus | sd_vin;
    assign w_gate     = otpi_gate & r_otpi_sync[SYNC_STG-1];
    // Counter is held at zero outside PWM so every entry starts a full slot 0
    assign w_clear    = !is_pwm(r_state);
    assign w_slot_nxt = w_slot_wrap ? (w_slot + SLOT_W'(1)) : w_slot;
    // Duty is only picked up when a new period begins
    assign w_duty_nxt = w_period_wrap ? sd_duty : r_duty;
    assign w_hi_nxt   = (w_slot_nxt <= w_duty_nxt);

    sdischg_slot_cnt #(
        .SLOT_DIV (SLOT_DIV)
    ) u_slot_cnt (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_clear),
        .o_slot          (w_slot),
        .o_slot_wrap_c   (w_slot_wrap),
        .o_period_wrap_c (w_period_wrap)
    );

    // Synchronise the asynchronous OTP interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_otpi_sync <= '0;
        end else begin
            r_otpi_sync <= {r_otpi_sync[SYNC_STG-2:0], otpi};
        end
    end

    // Mode FSM with duty latch and gated, registered switch enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_duty          <= '0;
            r_vo_dischg     <= 1'b0;
            r_vo_vin_dischg <= 1'b0;
            r_pwm_busy      <= 1'b0;
        end else begin
            r_vo_dischg     <= 1'b0;
            r_vo_vin_dischg <= 1'b0;
            r_pwm_busy      <= 1'b0;
            if (!dischg_en) begin
                r_state <= ST_IDLE;
            end else if (!w_sd_any) begin
                r_state     <= ST_BASIC;
                r_vo_dischg <= !w_gate;
            end else if (!is_pwm(r_state)) begin
                r_state         <= ST_PWM_HI;
                r_duty          <= sd_duty;
                r_vo_dischg     <= sd_vbus & !w_gate;
                r_vo_vin_dischg <= sd_vin & !w_gate;
                r_pwm_busy      <= 1'b1;
            end else begin
                r_duty     <= w_duty_nxt;
                r_pwm_busy <= 1'b1;
                if (w_hi_nxt) begin
                    r_state         <= ST_PWM_HI;
                    r_vo_dischg     <= sd_vbus & !w_gate;
                    r_vo_vin_dischg <= sd_vin & !w_gate;
                end else begin
                    r_state <= ST_PWM_LO;
                end
            end
        end
    end

    assign vo_dischg     = r_vo_dischg;
    assign vo_vin_dischg = r_vo_vin_dischg;
    assign pwm_busy      = r_pwm_busy;

endmodule

// File: tb/tb_sdischg_pwm.sv
// Directed bench for sdischg_pwm; durations are measured in clk cycles.
module tb_sdischg_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       dischg_en;
    logic [4:0] sd_duty;
    logic       sd_vin;
    logic       sd_vbus;
    logic       otpi_gate;
    logic       otpi;
    logic       vo_dischg;
    logic       vo_vin_dischg;
    logic       pwm_busy;

    int checks   = 0;
    int failures = 0;
    int n;

    bit phase_en  = 1'b0;
    int phase_err = 0;
    bit fall_en   = 1'b0;
    int falls     = 0;
    bit hi_watch  = 1'b0;
    int hi_seen   = 0;
    bit lo_watch  = 1'b0;
    int lo_seen   = 0;
    logic prev_vo = 1'b0;

    sdischg_pwm #(
        .SLOT_DIV (120),
        .SYNC_STG (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dischg_en     (dischg_en),
        .sd_duty       (sd_duty),
        .sd_vin        (sd_vin),
        .sd_vbus       (sd_vbus),
        .otpi_gate     (otpi_gate),
        .otpi          (otpi),
        .vo_dischg     (vo_dischg),
        .vo_vin_dischg (vo_vin_dischg),
        .pwm_busy      (pwm_busy)
    );

    always #5 clk = ~clk;

    // Background observers sampled on the inactive edge
    always @(negedge clk) begin
        if (phase_en && (vo_dischg !== vo_vin_dischg)) phase_err++;
        if (fall_en && (prev_vo === 1'b1) && (vo_dischg === 1'b0)) falls++;
        if (hi_watch && (vo_dischg !== 1'b0)) hi_seen++;
        if (lo_watch && (vo_dischg !== 1'b1)) lo_seen++;
        prev_vo = vo_dischg;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Length in cycles of the current run at level lvl, starting at the present sample
    task automatic run_len(input bit vin_sel, input logic lvl, input int budget, output int len);
        len = 1;
        while (len < budget) begin
            @(negedge clk);
            if ((vin_sel ? vo_vin_dischg : vo_dischg) !== lvl) break;
            len++;
        end
    endtask

    initial begin
        rst = 1'b1; dischg_en = 1'b0; sd_duty = 5'd0; sd_vin = 1'b0; sd_vbus = 1'b0;
        otpi_gate = 1'b0; otpi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vo", 32'(vo_dischg), 32'd0);
        chk("rst_vin", 32'(vo_vin_dischg), 32'd0);
        chk("rst_busy", 32'(pwm_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_vo", 32'(vo_dischg), 32'd0);

        // Basic level mode
        dischg_en = 1'b1;
        @(negedge clk);
        chk("t1_vo", 32'(vo_dischg), 32'd1);
        chk("t1_vin", 32'(vo_vin_dischg), 32'd0);
        chk("t1_busy", 32'(pwm_busy), 32'd0);
        repeat (50) @(negedge clk);
        chk("t1_vo_steady", 32'(vo_dischg), 32'd1);
        dischg_en = 1'b0;
        @(negedge clk);
        chk("t1_drop_vo", 32'(vo_dischg), 32'd0);

        // VBUS PWM, duty 1: 240 high / 3600 low
        sd_vbus = 1'b1; sd_duty = 5'd1; dischg_en = 1'b1;
        @(negedge clk);
        chk("t2_first_vo", 32'(vo_dischg), 32'd1);
        chk("t2_busy", 32'(pwm_busy), 32'd1);
        for (int p = 0; p < 3; p++) begin
            run_len(1'b0, 1'b1, 5000, n);
            chk($sformatf("t2_hi%0d", p), 32'(n), 32'd240);
            run_len(1'b0, 1'b0, 5000, n);
            chk($sformatf("t2_lo%0d", p), 32'(n), 32'd3600);
        end
        chk("t2_vin", 32'(vo_vin_dischg), 32'd0);
        dischg_en = 1'b0;
        @(negedge clk);
        chk("t2_drop_vo", 32'(vo_dischg), 32'd0);
        chk("t2_drop_busy", 32'(pwm_busy), 32'd0);

        // Both outputs, duty 30 then 31
        sd_vin = 1'b1; sd_vbus = 1'b1; sd_duty = 5'd30; dischg_en = 1'b1;
        @(negedge clk);
        phase_en = 1'b1;
        run_len(1'b0, 1'b1, 5000, n);
        chk("t3_hi0", 32'(n), 32'd3720);
        run_len(1'b0, 1'b0, 5000, n);
        chk("t3_lo0", 32'(n), 32'd120);
        sd_duty = 5'd31;
        run_len(1'b0, 1'b1, 5000, n);
        chk("t3_hi1", 32'(n), 32'd3720);
        run_len(1'b0, 1'b0, 5000, n);
        chk("t3_lo1", 32'(n), 32'd120);
        run_len(1'b0, 1'b1, 24000, n);
        chk("t3_full", 32'(n), 32'd24000);
        phase_en = 1'b0;
        chk("t3_phase", 32'(phase_err), 32'd0);
        sd_vin = 1'b0; sd_vbus = 1'b0;
        @(negedge clk);
        chk("t3_basic_vo", 32'(vo_dischg), 32'd1);
        chk("t3_basic_vin", 32'(vo_vin_dischg), 32'd0);
        chk("t3_basic_busy", 32'(pwm_busy), 32'd0);
        dischg_en = 1'b0;
        @(negedge clk);

        // VIN only, duty 20, mid-pulse rewrite to 2
        sd_vin = 1'b1; sd_vbus = 1'b0; sd_duty = 5'd20; dischg_en = 1'b1;
        hi_watch = 1'b1;
        @(negedge clk);
        repeat (99) @(negedge clk);
        chk("t4_mid_vin", 32'(vo_vin_dischg), 32'd1);
        sd_duty = 5'd2;
        run_len(1'b1, 1'b1, 5000, n);
        chk("t4_hi0", 32'(99 + n), 32'd2520);
        run_len(1'b1, 1'b0, 5000, n);
        chk("t4_lo0", 32'(n), 32'd1320);
        run_len(1'b1, 1'b1, 5000, n);
        chk("t4_hi1", 32'(n), 32'd360);
        run_len(1'b1, 1'b0, 5000, n);
        chk("t4_lo1", 32'(n), 32'd3480);
        hi_watch = 1'b0;
        chk("t4_vo_quiet", 32'(hi_seen), 32'd0);
        dischg_en = 1'b0; sd_vin = 1'b0;
        @(negedge clk);

        // OTP gating in basic mode
        otpi_gate = 1'b1; dischg_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_basic_vo", 32'(vo_dischg), 32'd1);
        otpi = 1'b1;
        @(negedge clk);
        chk("t5_sync1", 32'(vo_dischg), 32'd1);
        @(negedge clk);
        chk("t5_sync2", 32'(vo_dischg), 32'd1);
        @(negedge clk);
        chk("t5_gated", 32'(vo_dischg), 32'd0);
        otpi = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_release", 32'(vo_dischg), 32'd1);
        fall_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            otpi = 1'b1;
            repeat (72) @(negedge clk);
            otpi = 1'b0;
            repeat (40) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        fall_en = 1'b0;
        chk("t5_falls", 32'(falls), 32'd100);
        chk("t5_end_vo", 32'(vo_dischg), 32'd1);
        otpi_gate = 1'b0;
        @(negedge clk);
        lo_watch = 1'b1;
        for (int k = 0; k < 20; k++) begin
            otpi = 1'b1;
            repeat (72) @(negedge clk);
            otpi = 1'b0;
            repeat (40) @(negedge clk);
        end
        lo_watch = 1'b0;
        chk("t5_ungated", 32'(lo_seen), 32'd0);
        dischg_en = 1'b0;
        @(negedge clk);

        // Asynchronous reset during PWM_HI, then clean restart
        sd_vbus = 1'b1; sd_duty = 5'd1; dischg_en = 1'b1;
        @(negedge clk);
        repeat (50) @(negedge clk);
        chk("t6_pre_vo", 32'(vo_dischg), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_vo", 32'(vo_dischg), 32'd0);
        chk("t6_async_busy", 32'(pwm_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_restart_vo", 32'(vo_dischg), 32'd1);
        run_len(1'b0, 1'b1, 5000, n);
        chk("t6_first_hi", 32'(n), 32'd240);
        dischg_en = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
